// File: rtl/tthbif_cfg_rf.sv
// ============================================================================
// tthbif_cfg_rf : byte-command config register file (tap selects, ID, err_cnt)
// Optional readback path: define TTHBIF_CFG_READBACK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module tthbif_cfg_rf #(
  parameter int unsigned      SEL_W          = 2,
  parameter logic [SEL_W-1:0] SEL_RST        = '1,
  parameter int unsigned      TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]       ID_VALUE       = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             rx_data_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             tx_data_ready_i,
  output logic             tx_data_valid_o,
  output logic [7:0]       tx_data_o,
  output logic [SEL_W-1:0] rx_flop_tap_sel_o,
  output logic [SEL_W-1:0] rx_comb_tap_sel_o,
  output logic [SEL_W-1:0] tx_flop_tap_sel_o,
  output logic [SEL_W-1:0] tx_comb_tap_sel_o
);

  localparam int unsigned     C_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_TO_W-1:0] C_TO_ONE  = C_TO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q [4];
  logic [2:0]        addr_q;
  logic [C_TO_W-1:0] to_cnt_q;
  logic [7:0]        err_cnt_q;
  logic [7:0]        err_cnt_d;

  logic w_rsvd;
  logic w_err_inc;

  assign w_rsvd = |rx_data_i[6:3];

  // One error source per cycle at most, so a single saturating increment suffices.
  always_comb begin
    w_err_inc = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_IDLE:  w_err_inc = rx_data_valid_i && w_rsvd;
        ST_WDATA: w_err_inc = !rx_data_valid_i && (to_cnt_q == C_TO_LAST);
        default:  w_err_inc = rx_data_valid_i;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

`ifdef TTHBIF_CFG_READBACK_EN
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic [7:0] w_rd_data;

  always_comb begin
    w_rd_data = 8'h00;
    case (rx_data_i[2:0])
      3'd0:    w_rd_data = 8'(sel_q[0]);
      3'd1:    w_rd_data = 8'(sel_q[1]);
      3'd2:    w_rd_data = 8'(sel_q[2]);
      3'd3:    w_rd_data = 8'(sel_q[3]);
      3'd4:    w_rd_data = ID_VALUE;
      3'd5:    w_rd_data = err_cnt_q;
      default: w_rd_data = 8'h00;
    endcase
  end

  assign tx_data_valid_o = tx_valid_q;
  assign tx_data_o       = tx_data_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_data_ready_i;
  assign tx_data_valid_o = 1'b0;
  assign tx_data_o       = 8'h00;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= 3'd0;
      to_cnt_q  <= '0;
      err_cnt_q <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        sel_q[i] <= SEL_RST;
      end
`ifdef TTHBIF_CFG_READBACK_EN
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`endif
    end else begin
      err_cnt_q <= err_cnt_d;
      if (!en_i) begin
        state_q  <= ST_IDLE;
        to_cnt_q <= '0;
`ifdef TTHBIF_CFG_READBACK_EN
        tx_valid_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data_valid_i && !w_rsvd) begin
              if (rx_data_i[7]) begin
                addr_q   <= rx_data_i[2:0];
                to_cnt_q <= '0;
                state_q  <= ST_WDATA;
              end
`ifdef TTHBIF_CFG_READBACK_EN
              else begin
                tx_data_q  <= w_rd_data;
                tx_valid_q <= 1'b1;
                state_q    <= ST_RESP;
              end
`endif
            end
          end
          ST_WDATA: begin
            // Addresses 4-7 are read-only; their write data is swallowed.
            if (rx_data_valid_i) begin
              if (!addr_q[2]) begin
                sel_q[addr_q[1:0]] <= rx_data_i[SEL_W-1:0];
              end
              state_q <= ST_IDLE;
            end else if (to_cnt_q == C_TO_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              to_cnt_q <= to_cnt_q + C_TO_ONE;
            end
          end
`ifdef TTHBIF_CFG_READBACK_EN
          ST_RESP: begin
            if (tx_data_ready_i) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_flop_tap_sel_o = sel_q[0];
  assign rx_comb_tap_sel_o = sel_q[1];
  assign tx_flop_tap_sel_o = sel_q[2];
  assign tx_comb_tap_sel_o = sel_q[3];

endmodule

`default_nettype wire

// File: tb/tb_tthbif_cfg_rf.sv
// Bench for tthbif_cfg_rf: byte-level model plus directed command sequences.
`default_nettype none

module tb_tthbif_cfg_rf;
  localparam int TO = 8;
  localparam int SW = 2;
`ifdef TTHBIF_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          rxv = 1'b0;
  logic [7:0]    rxd = 8'h00;
  logic          ready = 1'b0;
  logic          txv;
  logic [7:0]    txd;
  logic [SW-1:0] rx_flop, rx_comb, tx_flop, tx_comb;

  always #5 clk = ~clk;

  tthbif_cfg_rf #(
    .SEL_W(SW), .SEL_RST('1), .TIMEOUT_CYCLES(TO), .ID_VALUE(8'hA5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .rx_data_valid_i(rxv), .rx_data_i(rxd), .tx_data_ready_i(ready),
    .tx_data_valid_o(txv), .tx_data_o(txd),
    .rx_flop_tap_sel_o(rx_flop), .rx_comb_tap_sel_o(rx_comb),
    .tx_flop_tap_sel_o(tx_flop), .tx_comb_tap_sel_o(tx_comb)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sel[4];
  int m_err;
  int m_waddr;   // -1 when no write is pending
  int m_wcnt;    // cycles spent waiting for the data byte
  bit m_resp;
  int m_txd;

  function void m_reset();
    for (int i = 0; i < 4; i++) m_sel[i] = (1 << SW) - 1;
    m_err = 0; m_waddr = -1; m_wcnt = 0; m_resp = 0; m_txd = 0;
  endfunction

  function void m_bump();
    if (m_err < 255) m_err = m_err + 1;
  endfunction

  function int rd_val(int a);
    if (a < 4) return m_sel[a];
    if (a == 4) return 8'hA5;
    if (a == 5) return m_err;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else if (!en) begin
      m_resp = 0; m_waddr = -1;
    end else if (m_resp) begin
      if (rxv) m_bump();
      if (ready) m_resp = 0;
    end else if (m_waddr >= 0) begin
      m_wcnt = m_wcnt + 1;
      if (rxv) begin
        if (m_waddr < 4) m_sel[m_waddr] = int'(rxd) % (1 << SW);
        m_waddr = -1;
      end else if (m_wcnt == TO) begin
        m_bump();
        m_waddr = -1;
      end
    end else if (rxv) begin
      if (rxd[6:3] != 4'b0) m_bump();
      else if (rxd[7]) begin m_waddr = int'(rxd[2:0]); m_wcnt = 0; end
      else if (RB) begin m_txd = rd_val(int'(rxd[2:0])); m_resp = 1; end
    end
  end

  always @(negedge clk) begin
    chk("cyc_rx_flop", 32'(rx_flop), 32'(m_sel[0]));
    chk("cyc_rx_comb", 32'(rx_comb), 32'(m_sel[1]));
    chk("cyc_tx_flop", 32'(tx_flop), 32'(m_sel[2]));
    chk("cyc_tx_comb", 32'(tx_comb), 32'(m_sel[3]));
    chk("cyc_tx_valid", 32'(txv), 32'(m_resp));
    chk("cyc_tx_data", 32'(txd), 32'(m_txd));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxv = 1'b1; rxd = b;
    tick();
    rxv = 1'b0;
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sels", {24'd0, rx_flop, rx_comb, tx_flop, tx_comb}, 32'hFF);
    chk("rst_tx_valid", 32'(txv), 32'd0);
    chk("rst_tx_data", 32'(txd), 32'd0);
    rst_n = 1'b1;
    tick();

    send(8'h81); send(8'h02);
    chk("wr_rx_comb", 32'(rx_comb), 32'h2);
    chk("wr_rx_flop_keep", 32'(rx_flop), 32'h3);
    send(8'h83); send(8'hFD);
    chk("wr_tx_comb_mask", 32'(tx_comb), 32'h1);
    send(8'h84); send(8'h00);
    chk("wr_ro_discard", {24'd0, rx_flop, rx_comb, tx_flop, tx_comb}, 32'b11_10_11_01);

`ifdef TTHBIF_CFG_READBACK_EN
    send(8'h03);
    chk("rd_valid_lat", 32'(txv), 32'd1);
    chk("rd_data", 32'(txd), 32'h01);
    repeat (5) begin
      tick();
      chk("rd_hold_valid", 32'(txv), 32'd1);
      chk("rd_hold_data", 32'(txd), 32'h01);
    end
    handshake();
    chk("rd_release", 32'(txv), 32'd0);
    send(8'h40);
    send(8'h05); chk("rd_err_rsvd", 32'(txd), 32'h01); handshake();
    send(8'h04); chk("rd_id", 32'(txd), 32'hA5); handshake();
`else
    send(8'h40); send(8'hC1); send(8'h03);
    chk("rsvd_no_write", 32'(rx_comb), 32'h2);
    send(8'h00);
    repeat (3) tick();
    chk("no_tx_activity", 32'(txv), 32'd0);
`endif

    // Timeout: nothing for TO cycles, next byte must be a fresh command.
    send(8'h80);
    repeat (TO) tick();
    send(8'h81); send(8'h01);
    chk("to_abandon", 32'(rx_flop), 32'h3);
    chk("to_next_cmd", 32'(rx_comb), 32'h1);
    // Data byte on the last permitted cycle is still taken.
    send(8'h80);
    repeat (TO - 1) tick();
    send(8'h02);
    chk("to_last_accept", 32'(rx_flop), 32'h2);

`ifdef TTHBIF_CFG_READBACK_EN
    send(8'h05); chk("rd_err_to", 32'(txd), 32'h02); handshake();
    send(8'h02);
    ready = 1'b1; rxv = 1'b1; rxd = 8'h81;
    tick();
    ready = 1'b0; rxv = 1'b0;
    chk("hs_drop_done", 32'(txv), 32'd0);
    send(8'h05); chk("rd_err_drop", 32'(txd), 32'h03); handshake();
    repeat (300) send(8'h40);
    send(8'h05); chk("rd_err_sat", 32'(txd), 32'hFF); handshake();
`endif

    // Enable dropped during WDATA: pending write abandoned, byte ignored.
    send(8'h82);
    en = 1'b0; rxv = 1'b1; rxd = 8'h00;
    tick();
    en = 1'b1; rxv = 1'b0;
    send(8'h83); send(8'h02);
    chk("en_no_write", 32'(tx_flop), 32'h3);
    chk("en_next_cmd", 32'(tx_comb), 32'h2);

`ifdef TTHBIF_CFG_READBACK_EN
    send(8'h01);
    chk("rd_before_rst", 32'(txv), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(txv), 32'd0);
    chk("arst_tx_data", 32'(txd), 32'd0);
    chk("arst_sels", {24'd0, rx_flop, rx_comb, tx_flop, tx_comb}, 32'hFF);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tthbif_cfg_rf.md
# tthbif_cfg_rf

Byte-command configuration register file for the TT HBIF lane. It consumes the UART receive byte stream, decodes write and read commands, and holds the four tap-select registers that drive the `tthbif` delay-tap inputs. It sits between `uart` and `tthbif` inside `tthbif_top`. Read responses go back on the UART transmit valid/ready stream.

## Interface
- `SEL_W`, default 2: width of each tap-select register.
- `SEL_RST`, default all-ones (`'1`): reset value of every tap-select register.
- `TIMEOUT_CYCLES`, default 1000000: maximum wait for a write data byte; must be ≥ 2.
- `ID_VALUE`, default 8'hA5: constant returned by a read of address 4.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `en_i` in 1: block enable.
- `rx_data_valid_i` in 1: one-cycle strobe; a received byte is present.
- `rx_data_i` in 8: received byte.
- `tx_data_ready_i` in 1: transmitter can accept a byte.
- `tx_data_valid_o` out 1: response byte is valid.
- `tx_data_o` out 8: response byte.
- `rx_flop_tap_sel_o` out SEL_W: register at address 0.
- `rx_comb_tap_sel_o` out SEL_W: register at address 1.
- `tx_flop_tap_sel_o` out SEL_W: register at address 2.
- `tx_comb_tap_sel_o` out SEL_W: register at address 3.

## Operation
- Command byte format: bit7 = 1 for write, 0 for read. Bits[6:3] are reserved and must be 0. Bits[2:0] are the address.
- Address map:
  - 0–3: tap selects (read/write).
  - 4: `ID_VALUE` (read-only).
  - 5: `err_cnt` (read-only, 8-bit, saturating at 255).
  - 6–7: read as 8'h00.
- FSM states: IDLE, WDATA, RESP.
- In IDLE, on a byte:
  - Reserved bits nonzero: increment `err_cnt`, stay in IDLE.
  - Write command: latch the address, go to WDATA.
  - Read command: load `tx_data_o` with the zero-extended register value, go to RESP.
- In WDATA:
  - Next byte: write `data[SEL_W-1:0]` to the addressed register, return to IDLE. Upper data bits are ignored. Writes to addresses 4–7 are discarded silently.
  - Timeout: increment `err_cnt`, return to IDLE.
- In RESP:
  - `tx_data_valid_o` is high. When `tx_data_valid_o && tx_data_ready_i`, return to IDLE.
  - Any rx byte arriving in RESP is dropped and increments `err_cnt`. This includes a byte arriving in the handshake cycle.
- `en_i` low:
  - FSM is forced to IDLE, `tx_data_valid_o` goes to 0, the timeout counter clears, and rx bytes are ignored without counting as errors.
  - Registers and `err_cnt` hold their values.
- `err_cnt` saturates at 8'hFF; it never wraps. A read of address 5 returns the value present before that command.

## Timing
- Reset values:
  - All tap selects = `SEL_RST`.
  - `err_cnt` = 0, FSM = IDLE.
  - `tx_data_valid_o` = 0, `tx_data_o` = 8'h00.
- Write latency: the tap-select output changes on the clock edge that samples the data byte, so it is visible the next cycle.
- Read latency: `tx_data_valid_o` rises the cycle after the command byte is sampled.
- `tx_data_o` is stable while `tx_data_valid_o` is high.
- Timeout counter:
  - Clears when WDATA is entered and counts each WDATA cycle with no valid byte.
  - A data byte arriving on the `TIMEOUT_CYCLES`-th cycle after the command is accepted.
  - With no byte by then, the FSM is in IDLE on the following cycle.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Asynchronous reset mid-command abandons the command with no partial register write.

## Configuration
- `TTHBIF_CFG_READBACK_EN` defined: read commands and the RESP state are implemented as above.
- Undefined:
  - RESP is not built. `tx_data_valid_o` and `tx_data_o` are tied to 0.
  - Valid read commands are consumed silently in IDLE and do not increment `err_cnt`.
  - Reserved-bit and timeout errors still count.

## Test plan
- Reset: all selects = 2'b11, `tx_data_valid_o` = 0, `err_cnt` = 0. Then bytes 8'h81, 8'h02 → `rx_comb_tap_sel_o` = 2'b10 on the cycle after the data byte; other selects unchanged.
- Bytes 8'h83, 8'hFD → `tx_comb_tap_sel_o` = 2'b01 (upper bits ignored). Then read 8'h03 with readback enabled → 8'h01 presented with valid the next cycle. Hold `tx_data_ready_i` low 5 cycles → data stable; handshake → IDLE.
- Byte 8'h40 (reserved bit set) → no state change; read 8'h05 → 8'h01. Read 8'h04 → 8'hA5.
- Write command 8'h80 with no data and `TIMEOUT_CYCLES` = 8:
  - No data byte → back in IDLE after 8 cycles, `err_cnt` incremented.
  - Repeat with the data byte on cycle 8 → write accepted.
- During RESP, inject an rx byte in the handshake cycle → byte dropped, `err_cnt` +1. Drive 300 errors → `err_cnt` reads 8'hFF.
- Deassert `en_i` while in WDATA → IDLE, no write. Assert `rst_ni` low mid-read → `tx_data_valid_o` = 0 immediately. Build without `TTHBIF_CFG_READBACK_EN`: read 8'h00 → no tx activity, `err_cnt` unchanged.
